// File: rtl/oam_dma_ctl_pkg.sv
// rtl/oam_dma_ctl_pkg.sv - shared encodings and address constants for the OAM DMA sequencer
package oam_dma_ctl_pkg;

  localparam logic [15:0] OAM_DMA_TRIG  = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  typedef enum logic {
    BUS_CPU = 1'b0,
    BUS_DMA = 1'b1
  } bus_owner_e;

endpackage

// File: rtl/oam_dma_ctl_if.sv
// rtl/oam_dma_ctl_if.sv - CPU-side and memory-side signals of the OAM DMA sequencer
interface oam_dma_ctl_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  mem_rdata;
  logic        cpu_halt;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_busy;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_halt, bus_sel, dma_addr, dma_wdata, dma_we, dma_busy
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_halt, bus_sel, dma_addr, dma_wdata, dma_we, dma_busy
  );

endinterface

// File: rtl/oam_dma_ctl.sv
// rtl/oam_dma_ctl.sv - sprite page DMA sequencer; OAM_DMA_ALIGN_EN adds the odd-parity ALIGN cycle
module oam_dma_ctl
  import oam_dma_ctl_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAM_DMA_TRIG,
  parameter logic [15:0] DEST_ADDR = OAM_DATA_PORT,
  parameter int          XFER_LEN  = 256
) (
  input  logic          clk,
  input  logic          rst,
  oam_dma_ctl_if.slave  bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e state;
  logic [7:0] page;
  logic [7:0] count;
  logic [7:0] latch;
  logic [7:0] count_nxt;

  assign count_nxt     = count + 8'd1;
  assign bus.dma_wdata = latch;

`ifdef OAM_DMA_ALIGN_EN
  logic cyc_odd;

  always_ff @(posedge clk) begin
    if (rst) cyc_odd <= 1'b0;
    else     cyc_odd <= ~cyc_odd;
  end
`endif

  // Outputs are registered alongside the state, so each is loaded with the
  // value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      page         <= 8'h00;
      count        <= 8'h00;
      latch        <= 8'h00;
      bus.cpu_halt <= 1'b0;
      bus.bus_sel  <= BUS_CPU;
      bus.dma_busy <= 1'b0;
      bus.dma_we   <= 1'b0;
      bus.dma_addr <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cpu_we && bus.cpu_addr == TRIG_ADDR) begin
            page         <= bus.cpu_wdata;
            state        <= ST_HALT;
            bus.cpu_halt <= 1'b1;
            bus.bus_sel  <= BUS_DMA;
            bus.dma_busy <= 1'b1;
            bus.dma_we   <= 1'b0;
          end
        end
        ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (cyc_odd) begin
            state <= ST_ALIGN;
          end else begin
            state        <= ST_READ;
            bus.dma_addr <= {page, count};
          end
`else
          state        <= ST_READ;
          bus.dma_addr <= {page, count};
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_ALIGN: begin
          state        <= ST_READ;
          bus.dma_addr <= {page, count};
        end
`endif
        ST_READ: begin
          latch        <= bus.mem_rdata;
          state        <= ST_WRITE;
          bus.dma_addr <= DEST_ADDR;
          bus.dma_we   <= 1'b1;
        end
        ST_WRITE: begin
          bus.dma_we <= 1'b0;
          if (count == LAST_IDX) begin
            // No carry into page: the copy always stays inside the source page.
            count        <= 8'h00;
            state        <= ST_IDLE;
            bus.cpu_halt <= 1'b0;
            bus.bus_sel  <= BUS_CPU;
            bus.dma_busy <= 1'b0;
            bus.dma_addr <= 16'h0000;
          end else begin
            count        <= count_nxt;
            state        <= ST_READ;
            bus.dma_addr <= {page, count_nxt};
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.cpu_halt <= 1'b0;
          bus.bus_sel  <= BUS_CPU;
          bus.dma_busy <= 1'b0;
          bus.dma_we   <= 1'b0;
          bus.dma_addr <= 16'h0000;
        end
      endcase
    end
  end

endmodule
